// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, ALU codes, state and immediate encodings for the control unit
package cpu_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  typedef enum logic [2:0] {CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH} cls_t;
  function automatic cls_t op_class(input logic [6:0] op);
    return op == OP_R      ? CL_R      :
           op == OP_I      ? CL_I      :
           op == OP_LOAD   ? CL_LOAD   :
           op == OP_STORE  ? CL_STORE  :
           op == OP_BRANCH ? CL_BRANCH : CL_NONE;
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps instruction class and {instr[30], funct3} to the ALU operation code
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  cls_t       cls,
  input  logic [3:0] alu_ctl,
  output logic [3:0] alu_op
);
  logic [3:0] code;
  logic [3:0] r_op;
  always_comb begin
    code = (cls == CL_I && alu_ctl[2:0] != 3'b101) ? {1'b0, alu_ctl[2:0]} : alu_ctl;
    r_op = ALU_ADD;
    case (code)
      4'b1000: r_op = ALU_SUB;
      4'b0111: r_op = ALU_AND;
      4'b0110: r_op = ALU_OR;
      4'b0100: r_op = ALU_XOR;
      4'b0010: r_op = ALU_SLT;
      4'b0001: r_op = ALU_SLL;
      4'b0101: r_op = ALU_SRL;
      4'b1101: r_op = ALU_SRA;
      default: r_op = ALU_ADD;
    endcase
    alu_op = (cls == CL_R || cls == CL_I)        ? r_op    :
             (cls == CL_LOAD || cls == CL_STORE) ? ALU_ADD :
             cls == CL_BRANCH                    ? ALU_SUB : ALU_AND;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [3:0]       alu_ctl,
  input  logic             zero,
  output logic             pc_en,
  output logic             pc_src,
  output logic             alu_src,
  output logic             mem_read_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       imm_sel,
  output logic [3:0]       alu_op,
  output logic             instr_done,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_count
);
  state_t           st;
  logic [6:0]       op_q;
  logic [3:0]       ctl_q;
  logic [CNT_W-1:0] cnt;
  cls_t             cls;
  logic [3:0]       ctl;
  logic [3:0]       dec_op;
  logic             in_dec;
  logic             busy;
  logic             taken;
  // DECODE sees the live fields so the outputs are already valid there and hold until retire
  assign in_dec = st == S_DECODE;
  assign cls    = op_class(in_dec ? opcode : op_q);
  assign ctl    = in_dec ? alu_ctl : ctl_q;
  assign busy   = !rst && cls != CL_NONE && st inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  assign taken  = (ctl[2:0] == 3'b000 && zero) || (ctl[2:0] == 3'b001 && !zero);
  alu_op_decoder u_dec (
    .cls     (cls),
    .alu_ctl (ctl),
    .alu_op  (dec_op)
  );
  assign illegal        = !rst && in_dec && cls == CL_NONE;
  assign pc_en          = illegal || (!rst && ((st == S_EXEC && cls == CL_BRANCH) ||
                                               (st == S_MEM && cls == CL_STORE) || st == S_WB));
  assign instr_done     = pc_en;
  assign pc_src         = !rst && st == S_EXEC && cls == CL_BRANCH && taken;
  assign alu_src        = busy && cls inside {CL_I, CL_LOAD, CL_STORE};
  assign imm_sel        = !busy ? IMM_I : cls == CL_STORE ? IMM_S : cls == CL_BRANCH ? IMM_B : IMM_I;
  assign alu_op         = busy ? dec_op : ALU_AND;
  assign mem_to_reg     = busy && cls == CL_LOAD;
  assign mem_read_write = !rst && st == S_MEM && cls == CL_STORE;
  assign reg_write      = !rst && st == S_WB;
  assign state          = rst ? 3'd0 : st;
  assign retire_count   = rst ? '0 : cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_FETCH;
      op_q  <= '0;
      ctl_q <= '0;
      cnt   <= '0;
    end else begin
      if (pc_en && !illegal) cnt <= cnt + 1'b1;
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          op_q  <= opcode;
          ctl_q <= alu_ctl;
          st    <= cls == CL_NONE ? S_FETCH : S_EXEC;
        end
        S_EXEC:   st <= (cls == CL_LOAD || cls == CL_STORE) ? S_MEM :
                        cls == CL_BRANCH ? S_FETCH : S_WB;
        S_MEM:    st <= cls == CL_LOAD ? S_WB : S_FETCH;
        default:  st <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle scoreboard of expected control vectors for each instruction class
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [3:0] alu_ctl;
  logic       zero;
  logic       pc_en, pc_src, alu_src, mem_read_write, mem_to_reg, reg_write, instr_done, illegal;
  logic [1:0] imm_sel;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic [3:0] retire_count;
  logic [20:0] obs;
  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;
  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] exp_cnt;
  always #5 clk = ~clk;
  multicycle_control_unit #(.CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .alu_ctl        (alu_ctl),
    .zero           (zero),
    .pc_en          (pc_en),
    .pc_src         (pc_src),
    .alu_src        (alu_src),
    .mem_read_write (mem_read_write),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
    .imm_sel        (imm_sel),
    .alu_op         (alu_op),
    .instr_done     (instr_done),
    .illegal        (illegal),
    .state          (state),
    .retire_count   (retire_count)
  );
  assign obs = {state, pc_en, pc_src, alu_src, mem_read_write, mem_to_reg, reg_write,
                illegal, instr_done, imm_sel, alu_op, retire_count};
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, obs, e.v);
    end
  end
  function automatic logic [20:0] mk(input logic [2:0] st, input logic pe, input logic ps,
                                     input logic as_, input logic mrw, input logic m2r,
                                     input logic rw, input logic ill, input logic [1:0] imm,
                                     input logic [3:0] aop, input logic [3:0] cnt);
    return {st, pe, ps, as_, mrw, m2r, rw, ill, pe, imm, aop, cnt};
  endfunction
  task automatic cyc(input string tag, input logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input string tag, input logic [6:0] op, input logic [3:0] ctl,
                       input logic z, input logic [3:0] aop, input logic as_,
                       input logic [1:0] imm, input logic tk, input int abort_at);
    logic [2:0] seq[$];
    logic       ld, sto, br, ill, last, held;
    logic [2:0] st;
    ld  = op == 7'b0000011;
    sto = op == 7'b0100011;
    br  = op == 7'b1100011;
    ill = !(ld || sto || br || op == 7'b0110011 || op == 7'b0010011);
    if (ill) seq = '{3'd0, 3'd1};
    else if (ld) seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    else if (sto) seq = '{3'd0, 3'd1, 3'd2, 3'd3};
    else if (br) seq = '{3'd0, 3'd1, 3'd2};
    else seq = '{3'd0, 3'd1, 3'd2, 3'd4};
    opcode  = op;
    alu_ctl = ctl;
    zero    = z;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        cyc($sformatf("%s_rst0", tag), '0);
        cyc($sformatf("%s_rst1", tag), '0);
        rst = 1'b0;
        exp_cnt = 4'd0;
        return;
      end
      st   = seq[i];
      last = i == seq.size() - 1;
      held = st != 3'd0 && !ill;
      cyc($sformatf("%s_c%0d", tag, i),
          mk(st, last, last && br && tk, held && as_, sto && st == 3'd3, held && ld,
             st == 3'd4, ill && st == 3'd1, held ? imm : 2'b00, held ? aop : 4'b0000, exp_cnt));
      if (last && !ill) exp_cnt = exp_cnt + 4'd1;
    end
  endtask
  initial begin
    rst     = 1'b1;
    opcode  = '0;
    alu_ctl = '0;
    zero    = 1'b0;
    exp_cnt = 4'd0;
    @(posedge clk);
    #1;
    cyc("reset0", '0);
    cyc("reset1", '0);
    rst = 1'b0;
    instr("r_sub",      7'b0110011, 4'b1000, 1'b0, 4'b0110, 1'b0, 2'b00, 1'b0, -1);
    instr("r_and",      7'b0110011, 4'b0111, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, -1);
    instr("r_unmapped", 7'b0110011, 4'b1001, 1'b0, 4'b0010, 1'b0, 2'b00, 1'b0, -1);
    instr("i_addi_b30", 7'b0010011, 4'b1000, 1'b0, 4'b0010, 1'b1, 2'b00, 1'b0, -1);
    instr("i_srai",     7'b0010011, 4'b1101, 1'b0, 4'b1010, 1'b1, 2'b00, 1'b0, -1);
    instr("i_srli",     7'b0010011, 4'b0101, 1'b0, 4'b1001, 1'b1, 2'b00, 1'b0, -1);
    instr("load",       7'b0000011, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'b00, 1'b0, -1);
    instr("store",      7'b0100011, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b0, -1);
    instr("beq_z1",     7'b1100011, 4'b0000, 1'b1, 4'b0110, 1'b0, 2'b10, 1'b1, -1);
    instr("bne_z1",     7'b1100011, 4'b0001, 1'b1, 4'b0110, 1'b0, 2'b10, 1'b0, -1);
    instr("bne_z0",     7'b1100011, 4'b0001, 1'b0, 4'b0110, 1'b0, 2'b10, 1'b1, -1);
    instr("blt_never",  7'b1100011, 4'b0100, 1'b1, 4'b0110, 1'b0, 2'b10, 1'b0, -1);
    instr("illegal",    7'b1111111, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, -1);
    instr("r_sub_post", 7'b0110011, 4'b1000, 1'b0, 4'b0110, 1'b0, 2'b00, 1'b0, -1);
    instr("r_abort_wb", 7'b0110011, 4'b1000, 1'b0, 4'b0110, 1'b0, 2'b00, 1'b0, 3);
    for (int k = 0; k < 17; k++)
      instr($sformatf("wrap%0d", k), 7'b0110011, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'b00, 1'b0, -1);
    check("wrap_final", {17'd0, retire_count}, 21'd1);
    check("queue_drained", 21'(q.size()), 21'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
